if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined CPU. It owns the program counter, drives the word address into the combinational instruction memory, and captures the returned instruction into the IF/ID pipeline register. It applies redirect (branch/jump), stall (hazard unit), flush and halt control from later stages, and keeps a retired-fetch counter for the bench.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- stall_i  in  1  hold PC and IF/ID contents (load-use hazard)
- flush_i  in  1  replace IF/ID contents with a bubble at this edge
- redirect_i  in  1  taken branch/jump resolved downstream
- redirect_pc_i  in  32  byte target of the redirect
- halt_i  in  1  stop fetching after this edge
- instr_i  in  32  instruction word returned by instruction memory for pc_addr_o (same cycle)
- pc_addr_o  out  32  current PC, byte address, to instruction memory
- ifid_pc4_o  out  32  PC+4 of the captured instruction
- ifid_instr_o  out  32  captured instruction
- ifid_valid_o  out  1  IF/ID holds a real instruction
- fetch_cnt_o  out  32  number of valid instructions written into IF/ID
- state_o  out  2  BOOT=0, RUN=1, HALT=2

## Operation
- Reset (rst_i low, asynchronous): pc_addr_o=RESET_PC, ifid_pc4_o=0, ifid_instr_o=0 (NOP), ifid_valid_o=0, fetch_cnt_o=0, state=BOOT.
- BOOT: lasts one cycle after reset release. PC holds, IF/ID takes a bubble, and all control inputs are ignored. Next state is RUN.
- RUN: at each edge, the PC and IF/ID updates follow the priority lists below.
- PC priority, highest first:
  - redirect_i: PC <= {redirect_pc_i[31:2],2'b00}. Misaligned targets are forced to word alignment.
  - stall_i: PC holds.
  - halt_i: PC holds and state goes to HALT.
  - otherwise: PC <= PC+4, wrapping mod 2^32.
- IF/ID priority, highest first:
  - redirect_i or flush_i: bubble (instr=0, pc4=0, valid=0).
  - stall_i: hold all IF/ID fields.
  - halt_i: bubble.
  - otherwise: instr <= instr_i, pc4 <= PC+4, valid <= 1.
- HALT: PC holds and IF/ID takes a bubble every edge. stall_i, flush_i and halt_i are ignored. redirect_i loads the PC as in RUN and returns the state to RUN. Only reset or redirect_i leaves HALT.
- A bubble equals `sll $0,$0,0` (all zeros), so downstream decode needs no valid gating.
- fetch_cnt_o increments by 1 only on edges where IF/ID is written with valid=1. It wraps mod 2^32 and does not change on stall-holds or bubbles.
- Simultaneous redirect_i and stall_i: the redirect wins, because it comes from an older instruction.
- Simultaneous stall_i and flush_i without redirect: the PC holds and IF/ID takes a bubble.

## Timing
- pc_addr_o is a register output. instr_i is combinational from it and is valid in the same cycle.
- Fetch latency is 1: the instruction at the PC of cycle n appears on ifid_instr_o in cycle n+1.
- Redirect penalty: a redirect sampled at edge k produces a bubble in IF/ID during cycle k+1. The target instruction appears in IF/ID during cycle k+2.
- All outputs change only on the rising clk_i edge, or asynchronously on rst_i assertion.
- Reset deasserted mid-operation: the block restarts from BOOT with pc_addr_o=RESET_PC. No partial state survives.

## Structure
- Shared package `cpu_pkg`:
  - NOP_INSTR = 32'h0
  - fetch state encodings FS_BOOT, FS_RUN, FS_HALT
  - the default RESET_PC
- One sub-module, `pc_reg`: the 32-bit PC register with async active-low reset, load enable and next-PC input.
- The next-PC mux, the IF/ID register, the FSM and the counter live in `if_stage`.

## Test plan
- Reset release, instruction memory preloaded with words equal to their index. After BOOT, pc_addr_o steps 0,4,8,… each cycle; ifid_instr_o follows one cycle later (0,1,2,…); fetch_cnt_o=3 after three RUN edges.
- stall_i held for 2 cycles at PC=8: pc_addr_o stays 8 and IF/ID keeps instr 1 with valid=1. fetch_cnt_o does not change during the stall and resumes counting when stall_i drops.
- redirect_i with redirect_pc_i=32'h0000_0043 asserted together with stall_i at PC=12: the next pc_addr_o is 32'h40, the next IF/ID is a bubble (valid=0, instr=0), and the following IF/ID holds instr 16.
- flush_i alone at PC=20: IF/ID becomes a bubble, pc_addr_o advances to 24, and fetch_cnt_o does not increment on that edge.
- halt_i at PC=28: state_o=2, pc_addr_o holds 28 with bubbles while stall_i and flush_i toggle. redirect_i to 0 then gives state_o=1 and pc_addr_o=0.
- Force the PC to 32'hFFFF_FFFC via redirect: the next pc_addr_o is 0. Asserting rst_i mid-run sets all outputs to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encodings, bubble word and reset PC.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] FS_BOOT = 2'd0;
    localparam logic [1:0] FS_RUN  = 2'd1;
    localparam logic [1:0] FS_HALT = 2'd2;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus: PC out, combinational instruction back.
interface if_stage_if;

    logic [31:0] pc_addr;
    logic [31:0] instr;

    modport master (output pc_addr, input  instr);
    modport slave  (input  pc_addr, output instr);

endinterface

// File: rtl/pc_reg.sv
// Program counter register with load enable and async active-low reset.
module pc_reg import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] pc_d_i,
    output logic [31:0] pc_q_o
);

    logic [31:0] pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= RESET_PC;
        end else if (en_i) begin
            pc_q <= pc_d_i;
        end
    end

    assign pc_q_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC sequencing, IF/ID register, fetch FSM and fetch counter.
module if_stage import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                redirect_i,
    input  logic [31:0]         redirect_pc_i,
    input  logic                halt_i,
    if_stage_if.master          imem,
    output logic [31:0]         ifid_pc4_o,
    output logic [31:0]         ifid_instr_o,
    output logic                ifid_valid_o,
    output logic [31:0]         fetch_cnt_o,
    output logic [1:0]          state_o
);

    logic [31:0] pc_q, pc_d, pc_plus4, tgt;
    logic        pc_en;
    logic [1:0]  state_q, state_d;
    logic [31:0] instr_q, pc4_q, cnt_q;
    logic        valid_q;
    logic        bubble, load;

    assign pc_plus4 = pc_q + 32'd4;
    assign tgt      = {redirect_pc_i[31:2], 2'b00};

    pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (pc_en),
        .pc_d_i (pc_d),
        .pc_q_o (pc_q)
    );

    always_comb begin
        pc_en   = 1'b0;
        pc_d    = pc_plus4;
        state_d = state_q;
        bubble  = 1'b0;
        load    = 1'b0;
        case (state_q)
            FS_RUN: begin
                if (redirect_i) begin
                    pc_en = 1'b1;
                    pc_d  = tgt;
                end else if (!stall_i) begin
                    if (halt_i) state_d = FS_HALT;
                    else        pc_en   = 1'b1;
                end
                // Redirect/flush beat stall; stall beats halt.
                if (redirect_i || flush_i) bubble = 1'b1;
                else if (stall_i)          bubble = 1'b0;
                else if (halt_i)           bubble = 1'b1;
                else                       load   = 1'b1;
            end
            FS_HALT: begin
                bubble = 1'b1;
                if (redirect_i) begin
                    pc_en   = 1'b1;
                    pc_d    = tgt;
                    state_d = FS_RUN;
                end
            end
            default: begin
                bubble  = 1'b1;
                state_d = FS_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= FS_BOOT;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (bubble) begin
                instr_q <= NOP_INSTR;
                pc4_q   <= 32'd0;
                valid_q <= 1'b0;
            end else if (load) begin
                instr_q <= imem.instr;
                pc4_q   <= pc_plus4;
                valid_q <= 1'b1;
                cnt_q   <= cnt_q + 32'd1;
            end
        end
    end

    assign imem.pc_addr = pc_q;
    assign ifid_pc4_o   = pc4_q;
    assign ifid_instr_o = instr_q;
    assign ifid_valid_o = valid_q;
    assign fetch_cnt_o  = cnt_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a behavioural fetch model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, redirect, halt;
    logic [31:0] redirect_pc;
    logic [31:0] ifid_pc4, ifid_instr, fetch_cnt;
    logic        ifid_valid;
    logic [1:0]  state;

    if_stage_if bus ();

    // Instruction memory: each word holds its own word index.
    assign bus.instr = bus.pc_addr >> 2;

    if_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .stall_i       (stall),
        .flush_i       (flush),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .halt_i        (halt),
        .imem          (bus.master),
        .ifid_pc4_o    (ifid_pc4),
        .ifid_instr_o  (ifid_instr),
        .ifid_valid_o  (ifid_valid),
        .fetch_cnt_o   (fetch_cnt),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid, m_boot, m_halt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_state();
        return m_boot ? 32'd0 : (m_halt ? 32'd2 : 32'd1);
    endfunction

    task automatic m_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
        m_cnt = 32'h0; m_valid = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
    endtask

    task automatic m_bubble();
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    bus.pc_addr,         m_pc);
        chk({tag, ".instr"}, ifid_instr,          m_instr);
        chk({tag, ".pc4"},   ifid_pc4,            m_pc4);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
        chk({tag, ".cnt"},   fetch_cnt,           m_cnt);
        chk({tag, ".state"}, {30'd0, state},      m_state());
    endtask

    task automatic step(input string tag);
        logic [31:0] word;
        @(posedge clk);
        word = m_pc >> 2;
        if (m_boot) begin
            m_boot = 1'b0;
            m_bubble();
        end else if (m_halt) begin
            m_bubble();
            if (redirect) begin
                m_pc = redirect_pc & 32'hFFFF_FFFC;
                m_halt = 1'b0;
            end
        end else begin
            if (redirect || flush) m_bubble();
            else if (stall) ;
            else if (halt) m_bubble();
            else begin
                m_instr = word; m_pc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
            end
            if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (stall) ;
            else if (halt) m_halt = 1'b1;
            else m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle();
        stall = 0; flush = 0; redirect = 0; halt = 0; redirect_pc = 32'h0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // Controls during BOOT must be ignored.
        redirect = 1; redirect_pc = 32'h100; stall = 1; halt = 1;
        step("boot");
        idle();
        repeat (3) step("run");
        chk("cnt_after3", fetch_cnt, 32'd3);

        stall = 1;
        repeat (2) step("stall");
        idle();
        step("unstall");

        redirect = 1; stall = 1; redirect_pc = 32'h0000_0043;
        step("redir_stall");
        chk("redir_pc", bus.pc_addr, 32'h40);
        chk("redir_bubble", ifid_valid ? 32'd1 : ifid_instr, 32'd0);
        idle();
        step("redir_tgt");
        chk("redir_instr", ifid_instr, 32'd16);

        flush = 1;
        step("flush");
        idle();
        step("post_flush");

        halt = 1;
        step("halt");
        chk("halt_state", {30'd0, state}, 32'd2);
        idle();
        for (int i = 0; i < 4; i++) begin
            stall = i[0]; flush = i[1]; halt = 1;
            step("halted");
        end
        idle();
        redirect = 1; redirect_pc = 32'h0;
        step("unhalt");
        chk("unhalt_state", {30'd0, state}, 32'd1);
        chk("unhalt_pc", bus.pc_addr, 32'h0);

        redirect = 1; redirect_pc = 32'hFFFF_FFFF;
        step("to_top");
        idle();
        step("wrap");
        chk("wrap_pc", bus.pc_addr, 32'h0);

        for (int i = 0; i < 400; i++) begin
            stall       = ($urandom_range(0, 5) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            halt        = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            step("rand");
        end
        idle();

        // Asynchronous reset between clock edges.
        #3 rst_n = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
